// File: rtl/uart_wb_sequencer.sv
// Wishbone master that configures a 16550-style UART, then arbitrates
// between sending pending TX bytes and draining received bytes on interrupt.
module uart_wb_sequencer #(
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [7:0] FCR_VALUE   = 8'hC7,
  parameter logic [7:0] IER_VALUE   = 8'h01
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        cfg_start,
  input  logic [7:0]  cfg_lcr,
  input  logic [15:0] cfg_divisor,
  output logic        cfg_done,
  output logic        err,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic [2:0]  wb_addr_o,
  output logic [7:0]  wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        int_i
);

  // Counter only needs to reach ACK_TIMEOUT-1: the abort fires on that
  // cycle when no ack is present.
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_IER_DLM = 3'd1;
  localparam logic [2:0] ADDR_IIR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_LSR     = 3'd5;

  typedef enum logic [2:0] {
    UNCFG, CFG, READY, TX_LSR, TX_THR, RX_IIR, RX_RBR, ERR
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      step_reg, step_next;
  logic [7:0]      lcr_reg, lcr_next;
  logic [15:0]     div_reg, div_next;
  logic            pend_valid_reg, pend_valid_next;
  logic [7:0]      pend_data_reg, pend_data_next;
  logic            rr_rx_reg, rr_rx_next;      // 1: RX wins the next tie
  logic            err_reg, err_next;
  logic            rx_valid_reg, rx_valid_next;
  logic [7:0]      rx_data_reg, rx_data_next;
  logic            bus_reg, bus_next;          // drives both cyc and stb
  logic            we_reg, we_next;
  logic [2:0]      addr_reg, addr_next;
  logic [7:0]      dat_reg, dat_next;
  logic [TW-1:0]   tmo_reg, tmo_next;

  logic            xfer_we;
  logic [2:0]      xfer_addr;
  logic [7:0]      xfer_dat;

  assign cfg_done  = (state_reg == READY)  || (state_reg == TX_LSR) ||
                     (state_reg == TX_THR) || (state_reg == RX_IIR) ||
                     (state_reg == RX_RBR);
  assign tx_ready  = cfg_done && !pend_valid_reg;
  assign err       = err_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_data   = rx_data_reg;
  assign wb_cyc_o  = bus_reg;
  assign wb_stb_o  = bus_reg;
  assign wb_we_o   = we_reg;
  assign wb_addr_o = addr_reg;
  assign wb_dat_o  = dat_reg;
  assign wb_sel_o  = 4'b0001;

  // Describe the bus transfer that the current state wants to issue.
  always_comb begin
    xfer_we   = 1'b0;
    xfer_addr = 3'd0;
    xfer_dat  = 8'h00;
    case (state_reg)
      CFG: begin
        xfer_we = 1'b1;
        case (step_reg)
          3'd0:    begin xfer_addr = ADDR_LCR;     xfer_dat = lcr_reg | 8'h80; end
          3'd1:    begin xfer_addr = ADDR_RBR_THR; xfer_dat = div_reg[7:0];    end
          3'd2:    begin xfer_addr = ADDR_IER_DLM; xfer_dat = div_reg[15:8];   end
          3'd3:    begin xfer_addr = ADDR_LCR;     xfer_dat = lcr_reg & 8'h7F; end
          3'd4:    begin xfer_addr = ADDR_IIR_FCR; xfer_dat = FCR_VALUE;       end
          default: begin xfer_addr = ADDR_IER_DLM; xfer_dat = IER_VALUE;       end
        endcase
      end
      TX_LSR: xfer_addr = ADDR_LSR;
      TX_THR: begin
        xfer_we   = 1'b1;
        xfer_addr = ADDR_RBR_THR;
        xfer_dat  = pend_data_reg;
      end
      RX_IIR: xfer_addr = ADDR_IIR_FCR;
      RX_RBR: xfer_addr = ADDR_RBR_THR;
      default: ;
    endcase
  end

  // Next-state, arbitration and bus-cycle control.
  always_comb begin
    state_next      = state_reg;
    step_next       = step_reg;
    lcr_next        = lcr_reg;
    div_next        = div_reg;
    pend_valid_next = pend_valid_reg;
    pend_data_next  = pend_data_reg;
    rr_rx_next      = rr_rx_reg;
    err_next        = err_reg;
    rx_valid_next   = 1'b0;
    rx_data_next    = rx_data_reg;
    bus_next        = bus_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    dat_next        = dat_reg;
    tmo_next        = tmo_reg;

    if (tx_valid && tx_ready) begin
      pend_valid_next = 1'b1;
      pend_data_next  = tx_data;
    end

    case (state_reg)
      UNCFG, ERR, READY: begin
        if (cfg_start) begin
          state_next = CFG;
          step_next  = 3'd0;
          lcr_next   = cfg_lcr;
          div_next   = cfg_divisor;
          err_next   = 1'b0;
        end else if (state_reg == READY) begin
          if (pend_valid_reg && (!int_i || !rr_rx_reg)) begin
            state_next = TX_LSR;
            rr_rx_next = 1'b1;
          end else if (int_i) begin
            state_next = RX_IIR;
            rr_rx_next = 1'b0;
          end
        end
      end
      default: begin
        // Bus is always idle on entry and for one cycle after each ack,
        // which provides the mandatory gap between transfers.
        if (!bus_reg) begin
          bus_next  = 1'b1;
          we_next   = xfer_we;
          addr_next = xfer_addr;
          dat_next  = xfer_dat;
          tmo_next  = '0;
        end else if (wb_ack_i) begin
          bus_next = 1'b0;
          case (state_reg)
            CFG: begin
              if (step_reg == 3'd5) state_next = READY;
              else                  step_next  = step_reg + 3'd1;
            end
            TX_LSR: begin
              if (wb_dat_i[5]) begin
                state_next = TX_THR;
              end else begin
                state_next = READY;
                rr_rx_next = 1'b1;
              end
            end
            TX_THR: begin
              pend_valid_next = 1'b0;
              state_next      = READY;
            end
            RX_IIR: begin
              if (wb_dat_i[3:0] == 4'b0100 || wb_dat_i[3:0] == 4'b1100)
                state_next = RX_RBR;
              else
                state_next = READY;
            end
            RX_RBR: begin
              rx_valid_next = 1'b1;
              rx_data_next  = wb_dat_i;
              state_next    = READY;
            end
            default: ;
          endcase
        end else if (tmo_reg == TMO_LAST) begin
          bus_next   = 1'b0;
          err_next   = 1'b1;
          state_next = ERR;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
    endcase
  end

  // State and output registers; reset aborts any bus cycle immediately.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg      <= UNCFG;
      step_reg       <= 3'd0;
      lcr_reg        <= 8'h00;
      div_reg        <= 16'h0000;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= 8'h00;
      rr_rx_reg      <= 1'b1;
      err_reg        <= 1'b0;
      rx_valid_reg   <= 1'b0;
      rx_data_reg    <= 8'h00;
      bus_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= 3'd0;
      dat_reg        <= 8'h00;
      tmo_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      step_reg       <= step_next;
      lcr_reg        <= lcr_next;
      div_reg        <= div_next;
      pend_valid_reg <= pend_valid_next;
      pend_data_reg  <= pend_data_next;
      rr_rx_reg      <= rr_rx_next;
      err_reg        <= err_next;
      rx_valid_reg   <= rx_valid_next;
      rx_data_reg    <= rx_data_next;
      bus_reg        <= bus_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      dat_reg        <= dat_next;
      tmo_reg        <= tmo_next;
    end
  end

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Testbench for uart_wb_sequencer: a Wishbone slave model logs each
// acknowledged transfer; tests push expected transfers and compare.
module tb_uart_wb_sequencer;

  logic        clk;
  logic        wb_rst_i;
  logic        cfg_start;
  logic [7:0]  cfg_lcr;
  logic [15:0] cfg_divisor;
  logic        cfg_done;
  logic        err;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [2:0]  wb_addr_o;
  logic [7:0]  wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i;
  logic        int_i;

  int checks;
  int passed;

  // slave model controls
  bit         no_ack;
  int         ack_delay;
  int         slave_cnt;
  logic [7:0] lsr_val, iir_val, rbr_val;

  // transfer encoding: {we, addr[2:0], data[7:0]}; reads log data 0
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  uart_wb_sequencer dut (
    .clk(clk), .wb_rst_i(wb_rst_i),
    .cfg_start(cfg_start), .cfg_lcr(cfg_lcr), .cfg_divisor(cfg_divisor),
    .cfg_done(cfg_done), .err(err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .int_i(int_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wishbone slave: single-cycle ack after ack_delay wait cycles.
  initial begin
    wb_ack_i  = 1'b0;
    wb_dat_i  = 8'h00;
    slave_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_ack_i) begin
        wb_ack_i  = 1'b0;
        slave_cnt = 0;
      end else if (wb_cyc_o && wb_stb_o) begin
        slave_cnt++;
        if (!no_ack && slave_cnt > ack_delay) begin
          wb_ack_i = 1'b1;
          if (!wb_we_o) begin
            case (wb_addr_o)
              3'd5:    wb_dat_i = lsr_val;
              3'd2:    wb_dat_i = iir_val;
              3'd0:    wb_dat_i = rbr_val;
              default: wb_dat_i = 8'h00;
            endcase
          end
          obs_q.push_back({wb_we_o, wb_addr_o, wb_we_o ? wb_dat_o : 8'h00});
          $display("[%0t] wb %s addr=%0d data=%02h", $time,
                   wb_we_o ? "wr" : "rd", wb_addr_o,
                   wb_we_o ? wb_dat_o : wb_dat_i);
        end
      end else begin
        slave_cnt = 0;
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) cyc1();
  endtask

  task automatic push_exp(input logic we, input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({we, a, d});
  endtask

  task automatic push_cfg_exp(input logic [7:0] lcr, input logic [15:0] div);
    push_exp(1'b1, 3'd3, lcr | 8'h80);
    push_exp(1'b1, 3'd0, div[7:0]);
    push_exp(1'b1, 3'd1, div[15:8]);
    push_exp(1'b1, 3'd3, lcr & 8'h7F);
    push_exp(1'b1, 3'd2, 8'hC7);
    push_exp(1'b1, 3'd1, 8'h01);
  endtask

  task automatic pulse_cfg(input logic [7:0] lcr, input logic [15:0] div);
    cfg_lcr     = lcr;
    cfg_divisor = div;
    cfg_start   = 1'b1;
    cyc1();
    cfg_start   = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    wb_rst_i = 1'b1;
    repeat (3) cyc1();
    got = {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, cfg_done, err,
           tx_ready, rx_valid, rx_data};
    checks++;
    if (got !== 27'd0) $display("FAIL reset_outputs got=%07h want=0000000", got);
    else passed++;
    wb_rst_i = 1'b0;
    repeat (4) cyc1();
    checks++;
    if ({wb_stb_o, cfg_done} !== 2'b00)
      $display("FAIL uncfg_idle stb/cfg_done got=%b want=00", {wb_stb_o, cfg_done});
    else passed++;
  endtask

  task automatic test_config();
    logic [11:0] got, want;
    push_cfg_exp(8'h03, 16'h0036);
    pulse_cfg(8'h03, 16'h0036);
    wait_obs(6, 200);
    checks++;
    if (obs_q.size() !== 6) $display("FAIL cfg_count got=%0d want=6", obs_q.size());
    else passed++;
    checks++;
    if (cfg_done !== 1'b0) $display("FAIL cfg_done_early got=%b want=0", cfg_done);
    else passed++;
    cyc1();
    checks++;
    if (cfg_done !== 1'b1) $display("FAIL cfg_done_rise got=%b want=1", cfg_done);
    else passed++;
    checks++;
    if ({tx_ready, wb_sel_o} !== 5'b1_0001)
      $display("FAIL cfg_ready_sel got=%b want=10001", {tx_ready, wb_sel_o});
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL cfg_txn missing want=%03h", want);
      else begin
        got = obs_q.pop_front();
        if (got !== want) $display("FAIL cfg_txn got=%03h want=%03h", got, want);
        else passed++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_tx();
    logic [11:0] got, want;
    repeat (2) cyc1();
    lsr_val = 8'h60;
    push_exp(1'b0, 3'd5, 8'h00);
    push_exp(1'b1, 3'd0, 8'h5A);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    cyc1();
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) $display("FAIL tx_capture tx_ready got=%b want=0", tx_ready);
    else passed++;
    wait_obs(2, 100);
    checks++;
    if (obs_q.size() !== 2) $display("FAIL tx_count got=%0d want=2", obs_q.size());
    else passed++;
    cyc1();
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL tx_ready_back got=%b want=1", tx_ready);
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL tx_txn missing want=%03h", want);
      else begin
        got = obs_q.pop_front();
        if (got !== want) $display("FAIL tx_txn got=%03h want=%03h", got, want);
        else passed++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_rx();
    logic [11:0] got, want;
    int rx_seen;
    repeat (2) cyc1();
    iir_val = 8'hC4;
    rbr_val = 8'hA5;
    push_exp(1'b0, 3'd2, 8'h00);
    push_exp(1'b0, 3'd0, 8'h00);
    int_i = 1'b1;
    wait_obs(1, 100);
    int_i = 1'b0;
    wait_obs(2, 100);
    checks++;
    if (rx_valid !== 1'b0) $display("FAIL rx_valid_early got=%b want=0", rx_valid);
    else passed++;
    cyc1();
    checks++;
    if ({rx_valid, rx_data} !== 9'h1A5)
      $display("FAIL rx_strobe got=%b/%02h want=1/a5", rx_valid, rx_data);
    else passed++;
    cyc1();
    checks++;
    if ({rx_valid, rx_data} !== 9'h0A5)
      $display("FAIL rx_hold got=%b/%02h want=0/a5", rx_valid, rx_data);
    else passed++;
    // non-data interrupt code: IIR read only, no strobe
    iir_val = 8'hC1;
    push_exp(1'b0, 3'd2, 8'h00);
    int_i = 1'b1;
    wait_obs(3, 100);
    int_i = 1'b0;
    rx_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc1();
      if (rx_valid) rx_seen++;
    end
    checks++;
    if (rx_seen !== 0) $display("FAIL rx_nodata_strobe got=%0d want=0", rx_seen);
    else passed++;
    checks++;
    if (obs_q.size() !== 3) $display("FAIL rx_count got=%0d want=3", obs_q.size());
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL rx_txn missing want=%03h", want);
      else begin
        got = obs_q.pop_front();
        if (got !== want) $display("FAIL rx_txn got=%03h want=%03h", got, want);
        else passed++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, want;
    wb_rst_i = 1'b1;
    repeat (2) cyc1();
    wb_rst_i = 1'b0;
    cyc1();
    push_cfg_exp(8'h83, 16'h0001);
    pulse_cfg(8'h83, 16'h0001);
    wait_obs(6, 200);
    cyc1();
    checks++;
    if (cfg_done !== 1'b1) $display("FAIL rr_cfg_done got=%b want=1", cfg_done);
    else passed++;
    lsr_val = 8'h00;
    iir_val = 8'hC1;
    push_exp(1'b0, 3'd2, 8'h00);
    push_exp(1'b0, 3'd5, 8'h00);
    push_exp(1'b0, 3'd2, 8'h00);
    int_i    = 1'b1;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    cyc1();
    tx_valid = 1'b0;
    wait_obs(9, 300);
    int_i   = 1'b0;
    lsr_val = 8'h60;
    checks++;
    if (tx_ready !== 1'b0) $display("FAIL rr_pending_kept tx_ready got=%b want=0", tx_ready);
    else passed++;
    push_exp(1'b0, 3'd5, 8'h00);
    push_exp(1'b1, 3'd0, 8'h3C);
    wait_obs(11, 300);
    checks++;
    if (obs_q.size() !== 11) $display("FAIL rr_count got=%0d want=11", obs_q.size());
    else passed++;
    cyc1();
    checks++;
    if (tx_ready !== 1'b1) $display("FAIL rr_tx_ready got=%b want=1", tx_ready);
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL rr_txn missing want=%03h", want);
      else begin
        got = obs_q.pop_front();
        if (got !== want) $display("FAIL rr_txn got=%03h want=%03h", got, want);
        else passed++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_ack_at_limit();
    logic [11:0] got, want;
    repeat (2) cyc1();
    lsr_val   = 8'h60;
    ack_delay = 254;
    push_cfg_exp(8'h03, 16'h1234);
    push_exp(1'b0, 3'd5, 8'h00);
    push_exp(1'b1, 3'd0, 8'h77);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    pulse_cfg(8'h03, 16'h1234);
    tx_valid = 1'b0;
    checks++;
    if ({cfg_done, tx_ready} !== 2'b00)
      $display("FAIL recfg_drop cfg_done/tx_ready got=%b want=00", {cfg_done, tx_ready});
    else passed++;
    wait_obs(1, 400);
    ack_delay = 0;
    wait_obs(8, 400);
    checks++;
    if (obs_q.size() !== 8) $display("FAIL limit_count got=%0d want=8", obs_q.size());
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL limit_err got=%b want=0", err);
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL limit_txn missing want=%03h", want);
      else begin
        got = obs_q.pop_front();
        if (got !== want) $display("FAIL limit_txn got=%03h want=%03h", got, want);
        else passed++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    logic [11:0] got, want;
    int stb_cycles;
    repeat (3) cyc1();
    no_ack = 1'b1;
    pulse_cfg(8'h9B, 16'h0000);
    stb_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (wb_stb_o) stb_cycles++;
      else if (stb_cycles > 0) break;
      cyc1();
    end
    checks++;
    if (stb_cycles !== 255) $display("FAIL tmo_stb_cycles got=%0d want=255", stb_cycles);
    else passed++;
    checks++;
    if ({err, cfg_done, wb_cyc_o, wb_stb_o, tx_ready} !== 5'b10000)
      $display("FAIL tmo_flags got=%b want=10000",
               {err, cfg_done, wb_cyc_o, wb_stb_o, tx_ready});
    else passed++;
    stb_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      cyc1();
      if (wb_stb_o || !err) stb_cycles++;
    end
    checks++;
    if (stb_cycles !== 0) $display("FAIL err_sticky got=%0d want=0", stb_cycles);
    else passed++;
    no_ack = 1'b0;
    push_cfg_exp(8'h9B, 16'h0000);
    pulse_cfg(8'h9B, 16'h0000);
    checks++;
    if (err !== 1'b0) $display("FAIL err_clear got=%b want=0", err);
    else passed++;
    wait_obs(6, 200);
    cyc1();
    checks++;
    if (cfg_done !== 1'b1) $display("FAIL tmo_recfg_done got=%b want=1", cfg_done);
    else passed++;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL tmo_txn missing want=%03h", want);
      else begin
        got = obs_q.pop_front();
        if (got !== want) $display("FAIL tmo_txn got=%03h want=%03h", got, want);
        else passed++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [26:0] got;
    bit saw_stb;
    int stb_cycles;
    repeat (2) cyc1();
    ack_delay = 3;
    pulse_cfg(8'h03, 16'h0036);
    saw_stb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wb_stb_o) begin
        saw_stb = 1'b1;
        break;
      end
      cyc1();
    end
    checks++;
    if (saw_stb !== 1'b1) $display("FAIL mid_stb_seen got=%b want=1", saw_stb);
    else passed++;
    wb_rst_i = 1'b1;
    #1;
    got = {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, cfg_done, err,
           tx_ready, rx_valid, rx_data};
    checks++;
    if (got !== 27'd0) $display("FAIL mid_reset_outputs got=%07h want=0000000", got);
    else passed++;
    repeat (2) cyc1();
    wb_rst_i  = 1'b0;
    ack_delay = 0;
    obs_q.delete();
    exp_q.delete();
    stb_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      cyc1();
      if (wb_stb_o || wb_cyc_o) stb_cycles++;
    end
    checks++;
    if (stb_cycles !== 0 || obs_q.size() !== 0)
      $display("FAIL mid_no_strobe got=%0d/%0d want=0/0", stb_cycles, obs_q.size());
    else passed++;
    checks++;
    if ({cfg_done, tx_ready} !== 2'b00)
      $display("FAIL mid_uncfg got=%b want=00", {cfg_done, tx_ready});
    else passed++;
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    wb_rst_i    = 1'b1;
    cfg_start   = 1'b0;
    cfg_lcr     = 8'h00;
    cfg_divisor = 16'h0000;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    int_i       = 1'b0;
    no_ack      = 1'b0;
    ack_delay   = 0;
    lsr_val     = 8'h00;
    iir_val     = 8'h00;
    rbr_val     = 8'h00;
    test_reset();
    test_config();
    test_tx();
    test_rx();
    test_back_to_back();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
